// File: rtl/nios2core_cmd_master_pkg.sv
// Shared types and constants for the Avalon-MM command master.
package nios2core_cmd_master_pkg;

    localparam int LAT_W  = 4;
    localparam int DATA_W = 32;

    // Transaction phases: wait for a command, drive the strobe, wait out the
    // slave read latency, hold the response until it is consumed.
    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RDWAIT,
        RESP
    } state_e;

endpackage

// File: rtl/nios2core_cmd_master.sv
// Avalon-MM initiator: one valid/ready command becomes one single-word
// read or write transfer, followed by exactly one response.
module nios2core_cmd_master
    import nios2core_cmd_master_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_write,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata
);

    // A zero timeout still needs a 1-bit counter; it simply never fires.
    localparam int               TMO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                avm_read_q, avm_read_d;
    logic                avm_write_q, avm_write_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_write_q, rsp_write_d;
    logic                rsp_tmo_q, rsp_tmo_d;

    logic [TMO_W-1:0]    tmo_inc;
    logic                tmo_hit;

    // Saturating stall count; the limit is checked against the value this edge would store.
    assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_inc == TMO_LIMIT);

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        // NOTE: every *_d gets its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        avm_read_d  = avm_read_q;
        avm_write_d = avm_write_q;
        tmo_d       = tmo_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_write_d = rsp_write_q;
        rsp_tmo_d   = rsp_tmo_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    is_write_d  = cmd_write;
                    addr_d      = cmd_address;
                    wdata_d     = cmd_writedata;
                    tmo_d       = '0;
                    cmd_ready_d = 1'b0;
                    avm_read_d  = ~cmd_write;
                    avm_write_d = cmd_write;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (!avm_waitrequest) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    lat_d       = '0;
                    if (is_write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_write_d = 1'b1;
                        rsp_tmo_d   = 1'b0;
                        state_d     = RESP;
                    end else begin
                        state_d = RDWAIT;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        avm_read_d  = 1'b0;
                        avm_write_d = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_write_d = is_write_q;
                        rsp_tmo_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RDWAIT: begin
                if (lat_q == LAT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = avm_readdata;
                    rsp_write_d = 1'b0;
                    rsp_tmo_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops strobes and the response at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            tmo_q       <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples values from before the edge.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            avm_read_q  <= avm_read_d;
            avm_write_q <= avm_write_d;
            tmo_q       <= tmo_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_write_q <= rsp_write_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_readdata  = rsp_rdata_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_timeout   = rsp_tmo_q;
    assign avm_address   = addr_q;
    assign avm_read      = avm_read_q;
    assign avm_write     = avm_write_q;
    assign avm_writedata = wdata_q;

endmodule

// File: tb/tb_nios2core_cmd_master.sv
// Self-checking bench: vector table plus hand-written backpressure,
// back-to-back and reset sequences; responses checked through a scoreboard.
module tb_nios2core_cmd_master;

    localparam int ADDR_W = 16;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        int                stall;
        logic              stuck;
        int                exp_lat;
        int                exp_strobes;
        logic [31:0]       exp_rdata;
        logic              exp_tmo;
        logic [31:0]       exp_mem;
    } vec_t;

    typedef struct {
        logic        wr;
        logic        tmo;
        logic [31:0] rdata;
    } rsp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [31:0]       cmd_writedata;
    logic              rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0]       rsp_readdata;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read, avm_write, avm_waitrequest;
    logic [31:0]       avm_writedata, avm_readdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    rsp_t exp_q[$];
    vec_t vec[10];

    always #5 clk = ~clk;

    nios2core_cmd_master #(
        .ADDR_W(ADDR_W),
        .READ_LATENCY(1),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_address(cmd_address),
        .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_readdata(rsp_readdata),
        .rsp_write(rsp_write),
        .rsp_timeout(rsp_timeout),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // GPIO-style slave: programmable stall, registered read data valid for one cycle only.
    logic [31:0] mem [16];
    logic [31:0] slv_rdata = 32'hDEAD_BEEF;
    int          stall_cfg = 0;
    logic        stuck = 1'b0;
    int          stall_seen = 0;
    logic        strobe;

    assign strobe          = avm_read | avm_write;
    assign avm_waitrequest = strobe && (stuck || (stall_seen < stall_cfg));
    assign avm_readdata    = slv_rdata;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= (i == 0) ? 32'h00A5_A5A5 : 32'(i) * 32'h0101_0101;
        end else if (avm_write && !avm_waitrequest) begin
            mem[avm_address[3:0]] <= avm_writedata;
        end
        stall_seen <= (strobe && avm_waitrequest) ? stall_seen + 1 : 0;
        slv_rdata  <= (avm_read && !avm_waitrequest) ? mem[avm_address[3:0]] : 32'hDEAD_BEEF;
    end

    // Monitor: strobe exclusivity, strobe cycle count, scoreboard pop on response handshake.
    int   strobe_total = 0;
    rsp_t mon_e;
    always @(negedge clk) begin
        if (reset_n) begin
            if (strobe) begin
                strobe_total <= strobe_total + 1;
                check("strobe_excl", 64'(avm_read & avm_write), 64'd0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_write", 64'(rsp_write), 64'(mon_e.wr));
                    check("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tmo));
                    check("rsp_readdata", 64'(rsp_readdata), 64'(mon_e.rdata));
                end
            end
        end
    end

    task automatic push_exp(input logic wr, input logic tmo, input logic [31:0] rdata);
        rsp_t e;
        e.wr    = wr;
        e.tmo   = tmo;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (!cmd_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int s0;
        stall_cfg = v.stall;
        stuck     = v.stuck;
        wait_idle();
        s0 = strobe_total;
        push_exp(v.wr, v.exp_tmo, v.exp_rdata);
        cmd_valid     = 1'b1;
        cmd_write     = v.wr;
        cmd_address   = v.addr;
        cmd_writedata = v.wdata;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d_strobes", idx), 64'(strobe_total - s0), 64'(v.exp_strobes));
        @(posedge clk); #1;
        stuck = 1'b0;
        if (v.wr)
            check($sformatf("v%0d_mem", idx), 64'(mem[v.addr[3:0]]), 64'(v.exp_mem));
    endtask

    task automatic backpressure_and_b2b();
        int   acc;
        int   cyc;
        int   last;
        int   lat;
        logic will;
        stall_cfg = 0;
        stuck     = 1'b0;
        wait_idle();
        rsp_ready = 1'b0;
        push_exp(1'b1, 1'b0, 32'h0);
        cmd_valid     = 1'b1;
        cmd_write     = 1'b1;
        cmd_address   = 16'd4;
        cmd_writedata = 32'hA0A0_A0A0;
        @(posedge clk); #1;
        // Next command is offered immediately and must wait.
        cmd_address   = 16'd8;
        cmd_writedata = 32'hB000_0008;
        for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0, 32'h0);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", i),
                  {28'd0, cmd_ready, rsp_valid, rsp_write, rsp_timeout, rsp_readdata},
                  {28'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0});
        end
        rsp_ready = 1'b1;
        acc  = 0;
        cyc  = 0;
        last = 0;
        while (acc < 3 && cyc < 60) begin
            will = cmd_ready;
            @(posedge clk); #1;
            cyc++;
            if (will) begin
                if (acc > 0) check($sformatf("b2b_spacing%0d", acc), 64'(cyc - last), 64'd3);
                last = cyc;
                acc++;
                if (acc < 3) begin
                    cmd_address   = 16'(8 + acc);
                    cmd_writedata = 32'hB000_0008 + 32'(acc);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        check("b2b_accepted", 64'(acc), 64'd3);
        wait_idle();
        check("bp_mem4", 64'(mem[4]), 64'hA0A0_A0A0);
        check("b2b_mem8", 64'(mem[8]), 64'hB000_0008);
        check("b2b_mem9", 64'(mem[9]), 64'hB000_0009);
        check("b2b_mem10", 64'(mem[10]), 64'hB000_000A);
    endtask

    task automatic reset_mid_xfer();
        int seen;
        stall_cfg = 0;
        stuck     = 1'b1;
        wait_idle();
        cmd_valid     = 1'b1;
        cmd_write     = 1'b0;
        cmd_address   = 16'd6;
        cmd_writedata = 32'h5555_5555;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst_pre_strobe", 64'(avm_read), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_ctrl", {58'd0, cmd_ready, rsp_valid, avm_read, avm_write, rsp_write, rsp_timeout},
              {58'd0, 6'b100000});
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_wdata", 64'(avm_writedata), 64'd0);
        check("rst_rdata", 64'(rsp_readdata), 64'd0);
        stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("rst_no_rsp", 64'(seen), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //         wr    addr   wdata         stall stuck lat str rdata         tmo   mem
        vec[0] = '{1'b1, 16'd1, 32'h0FFF_FFFF, 0, 1'b0, 2,  1, 32'h0,         1'b0, 32'h0FFF_FFFF};
        vec[1] = '{1'b0, 16'd0, 32'h0,         0, 1'b0, 3,  1, 32'h00A5_A5A5, 1'b0, 32'h0};
        vec[2] = '{1'b0, 16'd0, 32'h0,         4, 1'b0, 7,  5, 32'h00A5_A5A5, 1'b0, 32'h0};
        vec[3] = '{1'b1, 16'd5, 32'h1234_5678, 2, 1'b0, 4,  3, 32'h0,         1'b0, 32'h1234_5678};
        vec[4] = '{1'b0, 16'd5, 32'h0,         0, 1'b0, 3,  1, 32'h1234_5678, 1'b0, 32'h0};
        vec[5] = '{1'b0, 16'd1, 32'h0,         7, 1'b0, 10, 8, 32'h0FFF_FFFF, 1'b0, 32'h0};
        vec[6] = '{1'b0, 16'd3, 32'h0,         0, 1'b1, 9,  8, 32'h0,         1'b1, 32'h0};
        vec[7] = '{1'b1, 16'd7, 32'hFFFF_FFFF, 0, 1'b1, 9,  8, 32'h0,         1'b1, 32'h0707_0707};
        vec[8] = '{1'b1, 16'd2, 32'hCAFE_F00D, 0, 1'b0, 2,  1, 32'h0,         1'b0, 32'hCAFE_F00D};
        vec[9] = '{1'b0, 16'd2, 32'h0,         1, 1'b0, 4,  2, 32'hCAFE_F00D, 1'b0, 32'h0};

        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        cmd_address   = '0;
        cmd_writedata = '0;
        rsp_ready     = 1'b1;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {58'd0, cmd_ready, rsp_valid, avm_read, avm_write, rsp_write, rsp_timeout},
              {58'd0, 6'b100000});
        check("reset_addr", 64'(avm_address), 64'd0);
        check("reset_rdata", 64'(rsp_readdata), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 10; i++) run_vec(vec[i], i);

        backpressure_and_b2b();
        reset_mid_xfer();
        // Slave memory reloads on reset, so register 0 holds its initial value again.
        run_vec(vec[1], 100);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nios2core_cmd_master.md
# nios2core_cmd_master

Avalon-MM initiator that turns a valid/ready command stream into single-word Avalon-MM read/write transfers, and returns one response per command. It sits between a host-side command source (debug bridge, boot sequencer) and the Nios II core's memory-mapped peripherals such as the PIO/GPIO slaves. It is their other end: it drives `address`/`read`/`write`/`writedata`, honours `waitrequest` and collects registered `readdata`.

## Interface
- `ADDR_W`, default 16: Avalon word address width.
- `READ_LATENCY`, default 1: fixed slave read latency in cycles, legal range 1..8.
- `TIMEOUT_CYCLES`, default 255: maximum cycles `avm_waitrequest` may stall a transfer; 0 disables the timeout.
- Clocking: one clock, `clk`. Reset is asynchronous and active-low, `reset_n`.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on the edge where both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_address` in ADDR_W: target word address.
- `cmd_writedata` in 32: write payload; ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_readdata` out 32: read data; 0 for writes and for timeouts.
- `rsp_write` out 1: echo of `cmd_write`.
- `rsp_timeout` out 1: transfer was abandoned by the timeout.
- `avm_address` out ADDR_W: Avalon address.
- `avm_read` out 1: Avalon read strobe.
- `avm_write` out 1: Avalon write strobe.
- `avm_writedata` out 32: Avalon write data.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdata` in 32: slave read data.

## Operation
- FSM states: IDLE, XFER, RDWAIT, RESP. Reset enters IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On handshake: register address, data and direction; clear the timeout counter; go to XFER.
- XFER:
  - Assert `avm_read` or `avm_write`. Hold `avm_address` and `avm_writedata` stable.
  - Completing edge: the edge with `avm_waitrequest`=0. A write then goes to RESP; a read goes to RDWAIT.
  - Otherwise increment the timeout counter. When the count reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), deassert the strobe, set `rsp_timeout`=1, zero `rsp_readdata` and go to RESP.
- RDWAIT:
  - Strobes low. The latency counter counts READ_LATENCY edges after the completing edge.
  - On the last of those edges, capture `avm_readdata` into `rsp_readdata` and go to RESP.
- RESP:
  - `rsp_valid`=1. Outputs hold until the `rsp_valid`&`rsp_ready` edge, then go to IDLE.
  - `cmd_ready`=0 in every state except IDLE. One transaction is outstanding at most.
- Never assert `avm_read` and `avm_write` together.
- Counter widths:
  - Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
  - Latency counter is 4 bits.
- Reset values:
  - `cmd_ready`=1, since the FSM is in IDLE.
  - All other outputs are 0: `rsp_valid`, `rsp_readdata`, `rsp_write`, `rsp_timeout`, `avm_address`, `avm_read`, `avm_write`, `avm_writedata`.
- Reset mid-operation: strobes and `rsp_valid` drop asynchronously. A pending transfer or response is discarded with no retry.

## Timing
- Command accepted at edge E0. The strobe is high in the cycle after E0.
- Write with no stall: strobe high for one cycle; `rsp_valid` high in the next cycle, 2 cycles after E0.
- Read with no stall and READ_LATENCY=L:
  - Strobe high in cycle 1.
  - `avm_readdata` sampled at the end of cycle 1+L.
  - `rsp_valid` high in cycle 2+L (3 for the default L=1).
- Each stall cycle (`avm_waitrequest`=1) adds exactly one cycle.
- Timeout: with `avm_waitrequest` stuck at 1, the strobe is high for exactly TIMEOUT_CYCLES cycles, and `rsp_valid` rises in the following cycle.
- Back-to-back: `cmd_ready` returns in the cycle after the response handshake. Minimum command spacing is 3 cycles for writes and L+3 for reads.
- `rsp_ready` held low: the FSM stays in RESP indefinitely and no new command is accepted.

## Structure
- Package `nios2core_cmd_master_pkg` holds:
  - the state enum (IDLE, XFER, RDWAIT, RESP);
  - the localparams LAT_W=4 and DATA_W=32.
- Flat implementation. No sub-module is natural: both counters and the FSM are a few lines each.

## Test plan
- Write, no stall: cmd write addr 1, data 0x0FFFFFFF to a GPIO-style slave model -> one write strobe with addr 1 and data 0x0FFFFFFF; `rsp_valid` 2 cycles after acceptance; `rsp_write`=1, `rsp_timeout`=0, `rsp_readdata`=0.
- Read, L=1: slave register 0 = 0x00A5A5A5; cmd read addr 0 -> `rsp_valid` 3 cycles after acceptance; `rsp_readdata`=0x00A5A5A5.
- Stall: slave holds waitrequest 4 cycles on a read (L=1) -> strobe high 5 cycles; `rsp_valid` 7 cycles after acceptance; data correct.
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck at 1 -> strobe high exactly 8 cycles; `rsp_timeout`=1, `rsp_readdata`=0; next command is accepted normally.
- Backpressure and throughput: `rsp_ready` held low 10 cycles -> response outputs stable, `cmd_ready`=0; then 3 queued writes -> accepted every 3 cycles, strobes never overlap.
- Reset mid-XFER: `reset_n` pulsed low while the strobe is stalled -> all outputs at reset values immediately; no response is emitted afterwards; `cmd_ready`=1 after release.
